// File: rtl/mul_booth4_seq_pkg.sv
// Shared types and helpers for the sequential radix-4 Booth multiplier.
package mul_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        ZERO,
        P1,
        P2,
        M1,
        M2
    } digit_t;

    // One Booth step per bit pair of the operand extended by two bits.
    function automatic int nstep(input int w);
        return w / 2 + 1;
    endfunction

endpackage

// File: rtl/mul_booth4_seq_booth4_sel.sv
// Radix-4 Booth digit decode: turns {mq[1:0],last} into the signed addend.
module booth4_sel
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]              sel,
    input  logic signed [WIDTH+1:0] b_ext,
    output logic signed [WIDTH+3:0] addend
);

    digit_t                  dig;
    logic signed [WIDTH+3:0] b4;

    assign b4 = {{2{b_ext[WIDTH+1]}}, b_ext};

    always_comb begin
        dig = ZERO;
        case (sel)
            3'b001, 3'b010: dig = P1;
            3'b011:         dig = P2;
            3'b100:         dig = M2;
            3'b101, 3'b110: dig = M1;
            default:        dig = ZERO;
        endcase
    end

    always_comb begin
        addend = '0;
        case (dig)
            P1:      addend = b4;
            P2:      addend = b4 <<< 1;
            M1:      addend = -b4;
            M2:      addend = -(b4 <<< 1);
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/mul_booth4_seq.sv
// Sequential radix-4 Booth multiplier with start/done handshake and
// signed/unsigned mode; one Booth step per clock.
module mul_booth4_seq
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] p,
    output logic               overflow
);

    localparam int NSTEP = nstep(WIDTH);
    localparam int CW    = $clog2(NSTEP + 1);
    localparam int EW    = WIDTH + 2;
    localparam int AW    = WIDTH + 4;

    state_t               state, state_nx;
    logic                 load, step;
    logic signed [AW-1:0] acc, addend, sum, acc_nx;
    logic [EW-1:0]        mq, mq_nx;
    logic signed [EW-1:0] b_ext;
    logic                 last, sgn;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH:0]       hi;
    logic                 ovf_nx;

    booth4_sel #(.WIDTH(WIDTH)) u_sel (
        .sel    ({mq[1:0], last}),
        .b_ext  (b_ext),
        .addend (addend)
    );

    // Add the digit, then arithmetic shift of the combined {acc,mq} by two.
    assign sum    = acc + addend;
    assign acc_nx = {{2{sum[AW-1]}}, sum[AW-1:2]};
    assign mq_nx  = {sum[1:0], mq[EW-1:2]};

    assign prod   = {acc[WIDTH-3:0], mq};
    assign hi     = prod[2*WIDTH-1:WIDTH-1];
    assign ovf_nx = sgn ? ((hi != '0) && (hi != '1)) : (prod[2*WIDTH-1:WIDTH] != '0);

    assign busy = (state == CALC);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        case (state)
            IDLE: if (start) begin
                load     = 1'b1;
                state_nx = CALC;
            end
            CALC: begin
                step = 1'b1;
                if (cnt == CW'(NSTEP - 1)) state_nx = DONE;
            end
            DONE: begin
                state_nx = start ? CALC : IDLE;
                load     = start;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            mq       <= '0;
            b_ext    <= '0;
            last     <= 1'b0;
            sgn      <= 1'b0;
            cnt      <= '0;
            done     <= 1'b0;
            p        <= '0;
            overflow <= 1'b0;
        end else begin
            done <= (state == DONE);
            if (state == DONE) begin
                p        <= prod;
                overflow <= ovf_nx;
            end
            if (load) begin
                acc   <= '0;
                mq    <= is_signed ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
                b_ext <= is_signed ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
                last  <= 1'b0;
                sgn   <= is_signed;
                cnt   <= '0;
            end else if (step) begin
                acc  <= acc_nx;
                mq   <= mq_nx;
                last <= mq[1];
                cnt  <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_mul_booth4_seq.sv
// Directed and randomized checks of mul_booth4_seq against a plain-arithmetic product model.
module tb_mul_booth4_seq;

    localparam int W   = 32;
    localparam int LAT = W / 2 + 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          is_signed = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic          busy, done, overflow;
    logic [2*W-1:0] p;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    mul_booth4_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .p         (p),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_p(input bit sg, input logic [31:0] x, input logic [31:0] y);
        longint          s;
        longint unsigned u;
        if (sg) begin
            s = longint'($signed(x)) * longint'($signed(y));
            return s;
        end
        u = {32'b0, x};
        u = u * {32'b0, y};
        return u;
    endfunction

    function automatic logic ref_ov(input bit sg, input logic [31:0] x, input logic [31:0] y);
        longint          s;
        longint unsigned u;
        if (sg) begin
            s = longint'($signed(x)) * longint'($signed(y));
            return (s < -64'sd2147483648) || (s > 64'sd2147483647);
        end
        u = {32'b0, x};
        u = u * {32'b0, y};
        return (u >> 32) != 0;
    endfunction

    // Drive a request; returns #1 after the accepting edge with its cycle stamp.
    task automatic launch(input bit sg, input logic [31:0] x, input logic [31:0] y, output int k);
        @(negedge clk);
        start = 1'b1; is_signed = sg; a = x; b = y;
        @(posedge clk); #1;
        k = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int k, input logic [63:0] ep, input logic eov);
        do begin
            @(posedge clk); #1;
        end while (!done && (cyc - k) < 60);
        chk({tag, "_lat"}, 64'(cyc - k), 64'(LAT));
        chk({tag, "_p"}, p, ep);
        chk({tag, "_ov"}, 64'(overflow), 64'(eov));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 64'(done), 64'd0);
    endtask

    task automatic do_op(input string tag, input bit sg, input logic [31:0] x, input logic [31:0] y);
        int k;
        launch(sg, x, y, k);
        wait_done(tag, k, ref_p(sg, x, y), ref_ov(sg, x, y));
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int k, k2, nb, seen;
        logic [31:0] x, y;
        bit sg;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_p", p, 64'd0);
        chk("rst_ov", 64'(overflow), 64'd0);
        @(negedge clk) rst = 1'b0;

        // signed -1 * -1 with busy-length check
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k);
        nb = busy ? 1 : 0;
        do begin
            @(posedge clk); #1;
            if (busy) nb++;
        end while (!done && (cyc - k) < 60);
        chk("t1_busy", 64'(nb), 64'd17);
        chk("t1_lat", 64'(cyc - k), 64'(LAT));
        chk("t1_p", p, 64'h1);
        chk("t1_ov", 64'(overflow), 64'd0);

        launch(1'b1, 32'd3, 32'hFFFF_FFFB, k);
        wait_done("t2", k, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        launch(1'b1, 32'h8000_0000, 32'h8000_0000, k);
        wait_done("t3", k, 64'h4000_0000_0000_0000, 1'b1);
        launch(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k);
        wait_done("t4u", k, 64'hFFFF_FFFE_0000_0001, 1'b1);
        launch(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, k);
        wait_done("t4s", k, 64'h1, 1'b0);

        // start re-pulsed with new operands mid-CALC must be ignored
        launch(1'b1, 32'd1234, 32'hFFFF_FF00, k);
        repeat (5) @(posedge clk);
        @(negedge clk);
        start = 1'b1; a = 32'h5555_5555; b = 32'd7; is_signed = 1'b0;
        @(negedge clk) start = 1'b0;
        wait_done("t5a", k, ref_p(1'b1, 32'd1234, 32'hFFFF_FF00), 1'b0);

        // start held in the DONE cycle: back-to-back accept
        launch(1'b0, 32'd100, 32'd200, k);
        do begin
            @(posedge clk); #1;
        end while (busy && (cyc - k) < 60);
        start = 1'b1; is_signed = 1'b1; a = 32'hFFFF_FFF9; b = 32'd6;
        @(posedge clk); #1;
        k2 = cyc;
        start = 1'b0;
        chk("t5b_lat1", 64'(k2 - k), 64'(LAT));
        chk("t5b_done1", 64'(done), 64'd1);
        chk("t5b_p1", p, 64'd20000);
        chk("t5b_busy2", 64'(busy), 64'd1);
        wait_done("t5b2", k2, 64'hFFFF_FFFF_FFFF_FFD6, 1'b0);

        // reset in the middle of CALC discards the operation
        launch(1'b1, 32'd7, 32'd9, k);
        repeat (8) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_done", 64'(done), 64'd0);
        chk("t6_p", p, 64'd0);
        chk("t6_ov", 64'(overflow), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (done || busy) seen++;
        end
        chk("t6_quiet", 64'(seen), 64'd0);
        do_op("t6_after", 1'b1, 32'd7, 32'd9);

        for (int i = 0; i < 1500; i++) begin
            x  = pick();
            y  = pick();
            sg = 1'($urandom_range(0, 1));
            do_op(sg ? "rnd_s" : "rnd_u", sg, x, y);
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
